bnn_conv_pe: RTL and testbench
==============================

# bnn_conv_pe

Parametrised binary convolution processing element for the BNN accelerator. It keeps a sliding window of the last K ifmap columns, with K selectable at run time up to KMAX. Each cycle it applies that window to OC independently loaded binary weight kernels, producing OC XNOR-popcount (or AND-popcount) results. Columns arrive from the ifmap line buffer one per cycle. Results leave through a valid/ready port to the threshold/pooling stage.

## Interface
- KMAX, 5: maximum kernel side; window is KMAX rows by KMAX columns.
- OC, 4: output channels (weight banks) computed in parallel.
- ACC_W, $clog2(KMAX*KMAX+1): width of each popcount result.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- kernel_k  in  3  active kernel side K. Value 0 is treated as 1; values > KMAX are treated as KMAX.
- mode  in  1  1 = XNOR-popcount, 0 = AND-popcount.
- load_weight  in  1  write weight_in into bank weight_ch.
- weight_ch  in  $clog2(OC)  target bank. Indices ≥ OC are ignored.
- weight_in  in  KMAX*KMAX  kernel bits; bit r*KMAX+c = row r, column c (c=0 oldest).
- row_start  in  1  new image row: clears window fill count.
- col_valid  in  1  ifmap_col_in valid.
- col_ready  out  1  column accepted when col_valid && col_ready.
- ifmap_col_in  in  KMAX  one column; bit r = row r.
- mac_valid  out  1  results valid.
- mac_ready  in  1  downstream accepts results.
- mac_out  out  OC*ACC_W  channel n at [n*ACC_W +: ACC_W].

## Operation
- Window: KMAX-deep column shift register. An accepted column shifts in as the newest column; the oldest column drops.
- Active region: rows 0..K-1 and the K newest columns. The newest column maps to weight column c=K-1; the oldest active column maps to c=0. All other bits are masked out of the count.
- Fill counter: saturates at K. It increments on each accepted column and resets to 0 on row_start.
- row_start together with an accepted column: the counter restarts from 1, and that column is the first of the new row.
- Compute trigger: an accepted column whose post-increment fill count ≥ K. The result is registered the next cycle. Columns accepted while fill < K produce no result.
- XNOR mode: count of positions where the ifmap bit equals the weight bit, over the K*K active positions. Range 0..K*K.
- AND mode: count of active positions where both bits are 1.
- Weight load: takes effect on the next edge. A compute in the same cycle as a load uses the old bank contents.
- kernel_k and mode are sampled on each compute. Changing them mid-row is legal, but the fill count is not recomputed; software issues row_start after a change of K.
- Reset mid-operation: all state is cleared immediately. No partial result is emitted after reset release.

## Timing
- Reset values: mac_valid=0, mac_out=0, col_ready=1, window=0, fill=0, all weight banks=0.
- col_ready = !mac_valid || mac_ready, a combinational one-stage skid.
- Latency: column accepted at edge t, result on mac_valid/mac_out after edge t (visible in cycle t+1).
- Throughput: one result per cycle once fill ≥ K and mac_ready is held high.
- Held output: while mac_valid && !mac_ready, mac_out is stable and no column is accepted.
- On mac_valid && mac_ready with no new compute, mac_valid drops the next cycle.

## Structure
- Package bnn_pkg holds: KMAX default, localparams MODE_AND=1'b0 and MODE_XNOR=1'b1, and a popcount-width helper function.
- Sub-module bnn_popcount (parameter N): purely combinational popcount of a masked KMAX*KMAX vector, instantiated OC times.
- Top level holds the window register, fill counter, weight banks, mask generation and output register.

## Test plan
- KMAX=5, OC=2, K=1, XNOR. Load bank0 = all ones, bank1 = all zeros. Send column 5'b00001. Next cycle: mac_valid=1, ch0=1, ch1=0.
- K=5, XNOR. Bank0 = all ones. Send 5 all-ones columns. Result after the 5th column only: ch0=25. A 6th column 5'b00000 gives ch0=20.
- K=5, AND mode, same weights. Send 5 columns of 5'b10101. Result ch0=15. Switch to XNOR with zero weights and send all-zero columns: ch0=25.
- Backpressure: hold mac_ready=0 for 3 cycles while results are pending. col_ready=0 and mac_out is unchanged for those 3 cycles. Releasing mac_ready resumes flow with no lost or duplicated column.
- row_start after 3 of 5 columns: no mac_valid until 5 further accepted columns.
- Assert rst_n=0 mid-stream: mac_valid, mac_out and weights read 0 immediately. After release, the first result appears only after K new columns.

Source files
------------

// File: rtl/bnn_pkg.sv
// bnn_pkg: shared constants and width helper for the BNN convolution PE.
// Ports: none (package). Provides KMAX_DEF, MODE_AND/MODE_XNOR, pcnt_w().
package bnn_pkg;
    localparam int   KMAX_DEF  = 5;
    localparam logic MODE_AND  = 1'b0;
    localparam logic MODE_XNOR = 1'b1;
    function automatic int pcnt_w(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/bnn_conv_pe_if.sv
// bnn_conv_pe_if: column input stream and result output stream of the PE.
// Ports: col_valid/col_ready/ifmap_col_in (columns in), mac_valid/mac_ready/mac_out (results out).
// master = the surrounding pipeline, slave = the PE.
interface bnn_conv_pe_if
    import bnn_pkg::*;
#(
    parameter int KMAX  = KMAX_DEF,
    parameter int OC    = 4,
    parameter int ACC_W = pcnt_w(KMAX * KMAX)
) ();
    logic                  col_valid;
    logic                  col_ready;
    logic [KMAX-1:0]       ifmap_col_in;
    logic                  mac_valid;
    logic                  mac_ready;
    logic [OC*ACC_W-1:0]   mac_out;
    modport master (output col_valid, ifmap_col_in, mac_ready, input col_ready, mac_valid, mac_out);
    modport slave  (input col_valid, ifmap_col_in, mac_ready, output col_ready, mac_valid, mac_out);
endinterface

// File: rtl/bnn_popcount.sv
// bnn_popcount: combinational count of set bits in an N-bit vector.
// Ports: v (input vector), cnt (number of ones, 0..N).
module bnn_popcount
    import bnn_pkg::*;
#(
    parameter int N = KMAX_DEF * KMAX_DEF,
    parameter int W = pcnt_w(N)
) (
    input  logic [N-1:0] v,
    output logic [W-1:0] cnt
);
    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) cnt = cnt + W'(v[i]);
    end
endmodule

// File: rtl/bnn_conv_pe.sv
// bnn_conv_pe: sliding-window binary convolution PE, OC parallel XNOR/AND popcounts.
// Ports: clk, rst_n (async active-low); kernel_k (K, clamped to 1..KMAX); mode (1=XNOR, 0=AND);
// load_weight/weight_ch/weight_in (bank write); row_start (clears fill); pe (column/result streams).
module bnn_conv_pe
    import bnn_pkg::*;
#(
    parameter int KMAX  = KMAX_DEF,
    parameter int OC    = 4,
    parameter int ACC_W = pcnt_w(KMAX * KMAX),
    parameter int CH_W  = OC > 1 ? $clog2(OC) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             kernel_k,
    input  logic                   mode,
    input  logic                   load_weight,
    input  logic [CH_W-1:0]        weight_ch,
    input  logic [KMAX*KMAX-1:0]   weight_in,
    input  logic                   row_start,
    bnn_conv_pe_if.slave           pe
);
    localparam int N  = KMAX * KMAX;
    localparam int FW = $clog2(KMAX + 1);
    localparam int CW = $clog2(KMAX);
    // win[0] is the newest column, win[KMAX-1] the oldest.
    logic [KMAX-1:0][KMAX-1:0] win, nwin, act;
    logic [OC-1:0][N-1:0]      bank, masked;
    logic [OC-1:0][ACC_W-1:0]  cnt;
    logic [FW-1:0]             fill, fill_nx;
    int                        k;
    logic                      acc, fire;
    assign pe.col_ready = !pe.mac_valid || pe.mac_ready;
    // The result is computed from the window as it will be after the incoming
    // column shifts in, so it can be registered on the accepting edge.
    assign nwin = {win[KMAX-2:0], pe.ifmap_col_in};
    always_comb begin
        k       = kernel_k == 3'd0 ? 1 : (int'(kernel_k) > KMAX ? KMAX : int'(kernel_k));
        acc     = pe.col_valid && pe.col_ready;
        fill_nx = row_start ? FW'(1) : (int'(fill) >= k ? FW'(k) : fill + FW'(1));
        fire    = acc && int'(fill_nx) >= k;
    end
    generate
        // Realign so weight column c sees window age k-1-c (newest column -> c=K-1).
        for (genvar c = 0; c < KMAX; c++) begin : g_col
            assign act[c] = c < k ? nwin[CW'(k - 1 - c)] : '0;
        end
        for (genvar n = 0; n < OC; n++) begin : g_ch
            for (genvar r = 0; r < KMAX; r++) begin : g_row
                for (genvar c = 0; c < KMAX; c++) begin : g_bit
                    assign masked[n][r*KMAX+c] = (r < k && c < k) &&
                        (mode == MODE_XNOR ? act[c][r] == bank[n][r*KMAX+c]
                                           : act[c][r] && bank[n][r*KMAX+c]);
                end
            end
            bnn_popcount #(.N(N), .W(ACC_W)) u_pc (.v(masked[n]), .cnt(cnt[n]));
        end
    endgenerate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win          <= '0;
            bank         <= '0;
            fill         <= '0;
            pe.mac_valid <= 1'b0;
            pe.mac_out   <= '0;
        end else begin
            if (acc) begin
                win  <= nwin;
                fill <= fill_nx;
            end else if (row_start) begin
                fill <= '0;
            end
            if (load_weight && int'(weight_ch) < OC) bank[weight_ch] <= weight_in;
            if (fire) begin
                pe.mac_valid <= 1'b1;
                pe.mac_out   <= cnt;
            end else if (pe.mac_ready) begin
                pe.mac_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bnn_conv_pe.sv
// tb_bnn_conv_pe: scoreboard bench for bnn_conv_pe (KMAX=5, OC=2) with a queue-based reference model.
module tb_bnn_conv_pe;
    localparam int KMAX = 5;
    localparam int OC   = 2;
    localparam int AW   = 5;
    logic                 clk, rst_n;
    logic [2:0]           kernel_k;
    logic                 mode, load_weight, row_start;
    logic [0:0]           weight_ch;
    logic [KMAX*KMAX-1:0] weight_in;
    bnn_conv_pe_if #(.KMAX(KMAX), .OC(OC), .ACC_W(AW)) pe ();
    bnn_conv_pe #(.KMAX(KMAX), .OC(OC), .ACC_W(AW), .CH_W(1)) dut (
        .clk(clk), .rst_n(rst_n), .kernel_k(kernel_k), .mode(mode),
        .load_weight(load_weight), .weight_ch(weight_ch), .weight_in(weight_in),
        .row_start(row_start), .pe(pe)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    int errors = 0;
    int checks = 0;
    // Reference model: column history (index 0 = newest), fill count, banks, output occupancy.
    logic [KMAX-1:0]      hist[$];
    logic [KMAX*KMAX-1:0] mb[OC];
    int                   mfill;
    bit                   mv, acc_flag;
    logic [OC*AW-1:0]     sb[$];
    logic [OC*AW-1:0]     last_exp;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    function automatic int ref_cnt(input int ch, input int k, input bit xnor_m);
        int n = 0;
        for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++) begin
                bit x = hist[k-1-c][r];
                bit w = mb[ch][r*KMAX+c];
                n += xnor_m ? int'(x == w) : int'(x & w);
            end
        return n;
    endfunction
    task automatic model_reset();
        hist.delete();
        repeat (KMAX) hist.push_back('0);
        for (int i = 0; i < OC; i++) mb[i] = '0;
        mfill = 0; mv = 0; acc_flag = 0; last_exp = '0;
        sb.delete();
    endtask
    // Evaluates what the coming clock edge does, given the inputs currently driven.
    task automatic model_edge();
        bit er, fire;
        int k;
        acc_flag = 0;
        if (!rst_n) return;
        er = !mv || pe.mac_ready;
        check("col_ready", 32'(pe.col_ready), 32'(er));
        check("mac_valid", 32'(pe.mac_valid), 32'(mv));
        acc_flag = pe.col_valid && er;
        k = kernel_k == 0 ? 1 : (kernel_k > KMAX ? KMAX : int'(kernel_k));
        fire = 0;
        if (acc_flag) begin
            hist.push_front(pe.ifmap_col_in);
            void'(hist.pop_back());
            mfill = row_start ? 1 : (mfill + 1 > k ? k : mfill + 1);
            if (mfill >= k) begin
                fire = 1;
                last_exp = {AW'(ref_cnt(1, k, mode)), AW'(ref_cnt(0, k, mode))};
                sb.push_back(last_exp);
            end
        end else if (row_start) begin
            mfill = 0;
        end
        if (fire) mv = 1;
        else if (pe.mac_ready) mv = 0;
        if (load_weight && int'(weight_ch) < OC) mb[weight_ch] = weight_in;
    endtask
    always begin
        @(negedge clk);
        #1;
        if (rst_n && pe.mac_valid && pe.mac_ready) begin
            if (sb.size() == 0) begin
                errors++; checks++;
                $display("FAIL sb_unexpected: got result %0h expected none", pe.mac_out);
            end else begin
                check("sb_result", 32'(pe.mac_out), 32'(sb.pop_front()));
            end
        end
    end
    task automatic tick();
        @(negedge clk);
        #3;
        model_edge();
        @(posedge clk);
        #1;
    endtask
    task automatic cyc(input bit vld, input logic [KMAX-1:0] col, input bit rs);
        pe.col_valid = vld; pe.ifmap_col_in = col; row_start = rs; load_weight = 0;
        tick();
    endtask
    task automatic ld(input bit ch, input logic [KMAX*KMAX-1:0] w);
        pe.col_valid = 0; row_start = 0; load_weight = 1; weight_ch = ch; weight_in = w;
        tick();
        load_weight = 0;
    endtask
    function automatic logic [31:0] chv(input int n);
        return 32'(pe.mac_out[n*AW +: AW]);
    endfunction
    task automatic do_reset();
        rst_n = 0;
        #1;
        check("rst_valid", 32'(pe.mac_valid), 0);
        check("rst_out", 32'(pe.mac_out), 0);
        check("rst_ready", 32'(pe.col_ready), 1);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [KMAX-1:0] col;
        kernel_k = 3'd1; mode = 1; load_weight = 0; row_start = 0; weight_ch = 0; weight_in = '0;
        pe.col_valid = 0; pe.ifmap_col_in = '0; pe.mac_ready = 1;
        do_reset();
        // K=1 XNOR, bank0 ones, bank1 zeros
        ld(0, '1); ld(1, '0);
        cyc(1, 5'b00001, 0);
        check("k1_valid", 32'(pe.mac_valid), 1);
        check("k1_ch0", chv(0), 1);
        check("k1_ch1", chv(1), 0);
        // K=5 XNOR, all-ones columns then one zero column
        kernel_k = 3'd5;
        cyc(1, '1, 1);
        repeat (3) cyc(1, '1, 0);
        check("k5_nofill", 32'(pe.mac_valid), 0);
        cyc(1, '1, 0);
        check("k5_ch0_25", chv(0), 25);
        check("k5_ch1_0", chv(1), 0);
        cyc(1, '0, 0);
        check("k5_ch0_20", chv(0), 20);
        check("k5_ch1_5", chv(1), 5);
        cyc(0, '0, 0);
        check("drop_valid", 32'(pe.mac_valid), 0);
        // AND mode, 10101 columns
        mode = 0;
        cyc(1, 5'b10101, 1);
        repeat (4) cyc(1, 5'b10101, 0);
        check("and_ch0_15", chv(0), 15);
        // XNOR, zero weights, zero columns
        mode = 1;
        ld(0, '0);
        cyc(1, '0, 1);
        repeat (4) cyc(1, '0, 0);
        check("xz_ch0_25", chv(0), 25);
        check("xz_ch1_25", chv(1), 25);
        // Backpressure with K=3
        ld(0, 25'h1abcdef);
        kernel_k = 3'd3;
        cyc(1, 5'h13, 1); cyc(1, 5'h0a, 0); cyc(1, 5'h1c, 0);
        pe.mac_ready = 0;
        repeat (3) begin
            cyc(1, 5'h05, 0);
            check("hold_ready", 32'(pe.col_ready), 0);
            check("hold_valid", 32'(pe.mac_valid), 1);
            check("hold_out", 32'(pe.mac_out), 32'(last_exp));
        end
        pe.mac_ready = 1;
        cyc(1, 5'h05, 0); cyc(1, 5'h11, 0);
        // row_start after 3 of 5 columns
        kernel_k = 3'd5;
        cyc(1, 5'h1f, 1); cyc(1, 5'h02, 0); cyc(1, 5'h07, 0);
        cyc(0, '0, 1);
        for (int i = 0; i < 4; i++) begin
            cyc(1, KMAX'($urandom), 0);
            check("rs_gap", 32'(pe.mac_valid), 0);
        end
        cyc(1, KMAX'($urandom), 0);
        check("rs_fifth", 32'(pe.mac_valid), 1);
        // Reset mid-stream with a held result
        kernel_k = 3'd1;
        cyc(1, 5'h1f, 1);
        pe.mac_ready = 0;
        cyc(0, '0, 0);
        do_reset();
        kernel_k = 3'd3; pe.mac_ready = 1;
        cyc(1, '0, 0); cyc(1, '0, 0);
        check("post_rst_fill", 32'(pe.mac_valid), 0);
        cyc(1, '0, 0);
        check("post_rst_valid", 32'(pe.mac_valid), 1);
        check("post_rst_ch0", chv(0), 9);
        check("post_rst_ch1", chv(1), 9);
        // Randomised traffic
        col = KMAX'($urandom);
        for (int i = 0; i < 600; i++) begin
            load_weight = ($urandom % 6) == 0;
            weight_ch = 1'($urandom);
            weight_in = 25'($urandom);
            row_start = 0;
            if ($urandom % 40 == 0) begin
                kernel_k = 3'($urandom);
                row_start = 1;
            end else if ($urandom % 50 == 0) begin
                row_start = 1;
            end
            if ($urandom % 12 == 0) mode = ~mode;
            pe.col_valid = ($urandom % 5) != 0;
            pe.ifmap_col_in = col;
            pe.mac_ready = ($urandom % 4) != 0;
            tick();
            if (acc_flag) col = KMAX'($urandom);
        end
        load_weight = 0; row_start = 0; pe.col_valid = 0; pe.mac_ready = 1;
        repeat (3) tick();
        check("sb_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
